// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and one-hot helpers for the 8-way
// round-robin arbiter.
package rr_arb_pkg;

  localparam int N     = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after ptr (mod N)
// whose request and mask bits are both set.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] cand;

  // Scan from the far end back toward ptr so the nearest hit is written last.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + IDX_W'(i);
      if (req[cand] && mask[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a hold limit that preempts a
// long-running owner when someone else is waiting.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic [7:0]       hold_cnt
);

  localparam logic [7:0] HoldLimit = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       hold_q, hold_d;

  logic [N-1:0]     pick_mask;
  logic [IDX_W-1:0] pick_ptr;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             others_req;
  logic             hand_off;

  rr_pick u_pick (
    .req     (req),
    .mask    (pick_mask),
    .ptr     (pick_ptr),
    .found   (pick_found),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // While granted, the search starts just past the owner and skips it, which
  // is exactly the order wanted for both release and preemption.
  always_comb begin
    pick_mask  = '1;
    pick_ptr   = ptr_q;
    others_req = |(req & ~gnt_q);
    hand_off   = 1'b0;
    if (state_q == GRANT) begin
      pick_mask = ~gnt_q;
      pick_ptr  = idx_q + IDX_W'(1);
      hand_off  = !req[idx_q] || ((hold_q == HoldLimit) && others_req);
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = idx_to_onehot(pick_idx);
          idx_d   = pick_idx;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (hand_off) begin
          ptr_d = pick_ptr;
          if (pick_found) begin
            gnt_d  = idx_to_onehot(pick_idx);
            idx_d  = pick_idx;
            hold_d = 8'd1;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            hold_d  = '0;
          end
        end else if (hold_q != HoldLimit) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = onehot_to_idx(gnt_q);
  assign gnt_valid = |gnt_q;
  assign hold_cnt  = hold_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8 built with a hold limit of 4 so preemption
// and saturation show up within a few cycles.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] hold_cnt;

  int assertCount = 0;
  int failCount   = 0;

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .hold_cnt  (hold_cnt)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] r);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expGnt,
                             input logic [2:0] expIdx, input logic [7:0] expHold);
    logic expValid;
    expValid = |expGnt;
    assertCount++;
    assert (gnt === expGnt) else begin
      failCount++;
      $error("[TB] FAIL %s gnt observed %h expected %h", tag, gnt, expGnt);
    end
    assertCount++;
    assert (gnt_idx === expIdx) else begin
      failCount++;
      $error("[TB] FAIL %s gnt_idx observed %0d expected %0d", tag, gnt_idx, expIdx);
    end
    assertCount++;
    assert (gnt_valid === expValid) else begin
      failCount++;
      $error("[TB] FAIL %s gnt_valid observed %b expected %b", tag, gnt_valid, expValid);
    end
    assertCount++;
    assert (hold_cnt === expHold) else begin
      failCount++;
      $error("[TB] FAIL %s hold_cnt observed %0d expected %0d", tag, hold_cnt, expHold);
    end
  endtask

  task automatic doReset();
    #3;
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held with every requester active; nothing may be granted.
    req = 8'hFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_hold", 8'h00, 3'd0, 8'd0);
    rst_n = 1'b1;
    applyStimulus(8'hFF);
    checkOutput("first_grant", 8'h01, 3'd0, 8'd1);

    // Each owner drops its request for one cycle: strict rotation 1..7,0.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(~(8'h01 << k));
      checkOutput("rotate", 8'h01 << ((k + 1) % 8), 3'((k + 1) % 8), 8'd1);
    end
    applyStimulus(8'h00);
    checkOutput("rotate_idle", 8'h00, 3'd0, 8'd0);

    // Release hands straight to the next waiter with no idle cycle.
    doReset();
    applyStimulus(8'b0010_0100);
    checkOutput("pair_first", 8'h04, 3'd2, 8'd1);
    applyStimulus(8'b0010_0100);
    checkOutput("pair_keep", 8'h04, 3'd2, 8'd2);
    applyStimulus(8'b0010_0000);
    checkOutput("pair_handoff", 8'h20, 3'd5, 8'd1);
    applyStimulus(8'b0000_0000);
    checkOutput("pair_idle", 8'h00, 3'd0, 8'd0);

    // Hold limit: 3 is preempted after its 4th cycle once 6 is waiting.
    applyStimulus(8'h08);
    checkOutput("pre_c1", 8'h08, 3'd3, 8'd1);
    applyStimulus(8'h48);
    checkOutput("pre_c2", 8'h08, 3'd3, 8'd2);
    applyStimulus(8'h48);
    checkOutput("pre_c3", 8'h08, 3'd3, 8'd3);
    applyStimulus(8'h48);
    checkOutput("pre_c4", 8'h08, 3'd3, 8'd4);
    applyStimulus(8'h48);
    checkOutput("pre_switch", 8'h40, 3'd6, 8'd1);
    applyStimulus(8'h48);
    checkOutput("pre_six_keep", 8'h40, 3'd6, 8'd2);
    applyStimulus(8'h08);
    checkOutput("pre_back_to3", 8'h08, 3'd3, 8'd1);

    // Lone requester 7: saturates at the limit and is never preempted.
    applyStimulus(8'h80);
    checkOutput("sat_start", 8'h80, 3'd7, 8'd1);
    for (int i = 2; i <= 100; i++) begin
      applyStimulus(8'h80);
      checkOutput("sat_hold", 8'h80, 3'd7, (i > 4) ? 8'd4 : 8'(i));
    end

    // Asynchronous reset in the middle of owner 5's grant.
    applyStimulus(8'h20);
    checkOutput("mid_owner5", 8'h20, 3'd5, 8'd1);
    applyStimulus(8'h21);
    checkOutput("mid_owner5_keep", 8'h20, 3'd5, 8'd2);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_async", 8'h00, 3'd0, 8'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(8'h21);
    checkOutput("post_reset_ptr0", 8'h01, 3'd0, 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
